// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and physical memory.
// The slave modport is the arbiter's view; master is the surrounding caches/memory.
interface pmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;

    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic [1:0]        arb_grant;

    modport slave (
        input  icache_read, icache_address,
        output icache_rdata, icache_resp,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output arb_grant
    );

    modport master (
        output icache_read, icache_address,
        input  icache_rdata, icache_resp,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  arb_grant
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between icache and dcache, holding each grant until pmem_resp.
// Define ARB_ROUND_ROBIN_EN to alternate the winner of simultaneous requests (default: dcache wins).
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input logic           clk,
    input logic           reset,
    pmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              dcache_req;
    logic              pick_d;

    assign dcache_req = bus.dcache_read | bus.dcache_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;  // priority register: 1 when the dcache owned the most recent grant
    assign pick_d = dcache_req & (~bus.icache_read | ~last_d);
`else
    assign pick_d = dcache_req;
`endif

    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.icache_rdata = bus.pmem_rdata;
    assign bus.dcache_rdata = bus.pmem_rdata;
    // Responses are forwarded in the pmem_resp cycle itself, never while reset is abandoning an access.
    assign bus.icache_resp  = ~reset & bus.pmem_resp & (state == GRANT_I);
    assign bus.dcache_resp  = ~reset & bus.pmem_resp & (state == GRANT_D);

    // NOTE: all state uses <= so every register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
            bus.arb_grant  <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            last_d         <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        // A read+write collision is resolved as a write-back.
                        state          <= GRANT_D;
                        addr_q         <= bus.dcache_address;
                        wdata_q        <= bus.dcache_wdata;
                        bus.pmem_write <= bus.dcache_write;
                        bus.pmem_read  <= ~bus.dcache_write;
                        bus.arb_grant  <= 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d         <= 1'b1;
`endif
                    end else if (bus.icache_read) begin
                        state          <= GRANT_I;
                        addr_q         <= bus.icache_address;
                        bus.pmem_read  <= 1'b1;
                        bus.pmem_write <= 1'b0;
                        bus.arb_grant  <= 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d         <= 1'b0;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (bus.pmem_resp) begin
                        state          <= IDLE;
                        bus.pmem_read  <= 1'b0;
                        bus.pmem_write <= 1'b0;
                        bus.arb_grant  <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(bus.dcache_read && bus.dcache_write))
        else $error("pmem_arbiter: dcache_read and dcache_write asserted together");
endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized scoreboard bench for pmem_arbiter: a request-level model predicts grant order,
// latched fields and latency; a monitor compares them against what appears on the memory port.
module tb_pmem_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit                d;
        logic [ADDR_W-1:0] addr;
        bit                wr;
        logic [LINE_W-1:0] wdata;
        bit                follows;
        int                issue_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    bit   mem_en = 1'b0;
    bit   rr_last_d = 1'b0;
    exp_t exp_q[$];

    pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory responder: random latency on real accesses, occasional stray pmem_resp while idle.
    initial begin
        int lat;
        lat = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                bus.pmem_resp = 1'b0;
                if (bus.pmem_read || bus.pmem_write) begin
                    if (lat == 0) begin
                        bus.pmem_resp  = 1'b1;
                        bus.pmem_rdata = rand_line();
                        lat = $urandom_range(0, 4);
                    end else begin
                        lat--;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.pmem_resp = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the expected grant whenever a new access appears on the memory port.
    initial begin
        exp_t cur;
        bit   active, prev, strobe, exp_i, exp_d;
        int   last_resp;
        active = 1'b0;
        prev = 1'b0;
        last_resp = -100;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                active = 1'b0;
                prev = 1'b0;
            end else begin
                strobe = bus.pmem_read | bus.pmem_write;
                if (strobe && !prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        active = 1'b1;
                        check("grant_owner", bus.arb_grant, cur.d ? 2'b10 : 2'b01);
                        check("grant_op", {bus.pmem_write, bus.pmem_read}, cur.wr ? 2'b10 : 2'b01);
                        check("grant_latency", cyc, cur.follows ? last_resp + 2 : cur.issue_cyc + 1);
                    end
                end
                if (active) begin
                    check("strobe_hold", strobe, 1);
                    check("pmem_address", bus.pmem_address, cur.addr);
                    if (cur.wr) check("pmem_wdata", bus.pmem_wdata, cur.wdata);
                end else begin
                    check("idle_outputs", {bus.arb_grant, bus.pmem_read, bus.pmem_write}, 0);
                end
                if (bus.pmem_resp || bus.icache_resp || bus.dcache_resp) begin
                    exp_i = active && !cur.d && bus.pmem_resp;
                    exp_d = active && cur.d && bus.pmem_resp;
                    check("resp_route", {bus.icache_resp, bus.dcache_resp}, {exp_i, exp_d});
                    if (exp_i) check("icache_rdata", bus.icache_rdata, bus.pmem_rdata);
                    if (exp_d) check("dcache_rdata", bus.dcache_rdata, bus.pmem_rdata);
                    if (active && bus.pmem_resp) begin
                        active = 1'b0;
                        last_resp = cyc;
                    end
                end
                prev = strobe;
            end
        end
    end

    // One round: icache alone, dcache alone, or both in the same cycle; wait for all to finish.
    task automatic run_round();
        int   kind, budget;
        bit   do_i, do_d, d_first, pend_i, pend_d;
        exp_t ei, ed;
        kind = $urandom_range(0, 2);
        do_i = (kind != 1);
        do_d = (kind != 0);
        @(posedge clk);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        ei = '{d: 1'b0, addr: ADDR_W'($urandom), wr: 1'b0, wdata: '0, follows: 1'b0, issue_cyc: cyc};
        ed = '{d: 1'b1, addr: ADDR_W'($urandom), wr: 1'($urandom), wdata: rand_line(),
               follows: 1'b0, issue_cyc: cyc};
        d_first = do_d && (!do_i || !RR || !rr_last_d);
        if (do_i && do_d) begin
            if (d_first) begin
                ei.follows = 1'b1;
                exp_q.push_back(ed);
                exp_q.push_back(ei);
            end else begin
                ed.follows = 1'b1;
                exp_q.push_back(ei);
                exp_q.push_back(ed);
            end
            rr_last_d = !d_first;
        end else begin
            exp_q.push_back(do_d ? ed : ei);
            rr_last_d = do_d;
        end
        bus.icache_read    = do_i;
        bus.icache_address = ei.addr;
        bus.dcache_read    = do_d & !ed.wr;
        bus.dcache_write   = do_d & ed.wr;
        bus.dcache_address = ed.addr;
        bus.dcache_wdata   = ed.wdata;
        pend_i = do_i;
        pend_d = do_d;
        budget = 0;
        while ((pend_i || pend_d) && budget < 300) begin
            @(negedge clk);
            budget++;
            if (bus.icache_resp && pend_i) begin
                pend_i = 1'b0;
                bus.icache_read = 1'b0;
            end
            if (bus.dcache_resp && pend_d) begin
                pend_d = 1'b0;
                bus.dcache_read = 1'b0;
                bus.dcache_write = 1'b0;
            end
            // Scramble the owner's inputs mid-grant; the latched copies must not move.
            if (pend_i && bus.arb_grant == 2'b01 && $urandom_range(0, 1) == 1)
                bus.icache_address = ADDR_W'($urandom);
            if (pend_d && bus.arb_grant == 2'b10 && $urandom_range(0, 1) == 1) begin
                bus.dcache_address = ADDR_W'($urandom);
                bus.dcache_wdata = rand_line();
            end
        end
        if (pend_i || pend_d) check("round_timeout", {pend_i, pend_d}, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.icache_read = 1'b0;
        bus.icache_address = '0;
        bus.dcache_read = 1'b0;
        bus.dcache_write = 1'b0;
        bus.dcache_address = '0;
        bus.dcache_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pmem_read", bus.pmem_read, 0);
        check("rst_pmem_write", bus.pmem_write, 0);
        check("rst_pmem_address", bus.pmem_address, 0);
        check("rst_pmem_wdata", bus.pmem_wdata, 0);
        check("rst_arb_grant", bus.arb_grant, 0);
        check("rst_resps", {bus.icache_resp, bus.dcache_resp}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        mem_en = 1'b1;

        for (int r = 0; r < 80; r++) run_round();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        mon_en = 1'b0;
        mem_en = 1'b0;

        // Reset two cycles into a dcache read abandons it; a late pmem_resp is not forwarded.
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        bus.dcache_read = 1'b1;
        bus.dcache_address = 16'h2468;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_pre_strobe", bus.pmem_read, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.dcache_read = 1'b0;
        @(negedge clk);
        check("mid_rst_pmem_read", bus.pmem_read, 0);
        check("mid_rst_arb_grant", bus.arb_grant, 0);
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        check("mid_rst_late_resp", {bus.icache_resp, bus.dcache_resp}, 0);
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        check("mid_rst_stays_idle", {bus.arb_grant, bus.pmem_read, bus.pmem_write}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
